// File: rtl/transcription_pkg.sv
// Shared types and helpers for the transcription sequencer: FSM states,
// note-length codes, the buffered event record and run-length quantisation.
package transcription_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNT_IN = 2'd1,
    TRACK    = 2'd2,
    FLUSH    = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    EIGHTH  = 2'd0,
    QUARTER = 2'd1,
    HALF    = 2'd2,
    WHOLE   = 2'd3
  } note_len_t;

  typedef struct packed {
    logic [5:0] tone;
    logic       rest;
    note_len_t  len;
  } note_event_t;

  localparam logic [5:0] SILENCE = 6'd0;

  function automatic note_len_t quantize_len(input logic [3:0] run_len);
    if (run_len >= 4'd8) return WHOLE;
    if (run_len >= 4'd4) return HALF;
    if (run_len >= 4'd2) return QUARTER;
    return EIGHTH;
  endfunction

  function automatic note_event_t make_event(input logic [5:0] tone, input note_len_t len);
    note_event_t ev;
    ev.tone = tone;
    ev.rest = (tone == SILENCE);
    ev.len  = len;
    return ev;
  endfunction

endpackage

// File: rtl/transcription_sequencer_fifo.sv
// Small in-order event buffer with a registered head entry; a push into a
// full buffer is accepted only when a pop frees a slot in the same cycle.
module event_fifo
  import transcription_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  note_event_t push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output note_event_t head
);

  localparam int AW = $clog2(DEPTH);

  note_event_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0]   count, count_nxt;
  logic          do_push, do_pop;
  note_event_t   head_nxt;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign rd_nxt    = do_pop ? rd_ptr + AW'(1) : rd_ptr;
  assign count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

  // The head bypasses storage when the pushed entry becomes the front
  always_comb begin
    head_nxt = mem[rd_nxt];
    if (do_push && (wr_ptr == rd_nxt)) head_nxt = push_data;
    if (count_nxt == '0) head_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
      head   <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/transcription_sequencer.sv
// Tempo-driven note transcriber: eighth-note time base, count-in metronome,
// run-length quantisation of sampled tones into buffered note/rest events.
module transcription_sequencer
  import transcription_pkg::*;
#(
  parameter int EIGHTH_CYCLES = 25_000_000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic       stop_in,
  input  logic [5:0] note_index,
  input  logic       note_index_ready,
  input  logic       event_ready,
  output logic       event_valid,
  output logic [5:0] event_tone,
  output logic       event_rest,
  output logic [1:0] event_len,
  output logic       beat_tick,
  output logic       busy,
  output logic       overflow
);

  localparam int               CNT_W    = (EIGHTH_CYCLES > 1) ? $clog2(EIGHTH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EIGHTH_CYCLES - 1);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick, parity;
  logic [2:0]       eighth_cnt, eighth_cnt_nxt;
  logic [5:0]       sample, held_tone, held_tone_nxt;
  logic [3:0]       run_len, run_len_nxt;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty, ovf_clr;
  note_event_t      push_ev, head_ev;

  assign busy      = (state != IDLE);
  assign tick      = busy && (tick_cnt == CNT_LAST);
  assign beat_tick = tick && parity && ((state == COUNT_IN) || (state == TRACK));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tick_cnt <= '0;
      parity   <= 1'b0;
    end else if (state == IDLE) begin
      tick_cnt <= '0;
      parity   <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
      parity   <= parity ^ tick;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      eighth_cnt <= '0;
      held_tone  <= SILENCE;
      run_len    <= '0;
      sample     <= SILENCE;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      eighth_cnt <= eighth_cnt_nxt;
      held_tone  <= held_tone_nxt;
      run_len    <= run_len_nxt;
      if (note_index_ready) sample <= note_index;
      if (ovf_clr) overflow <= 1'b0;
      else if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  // A stop coinciding with a tick in TRACK wins; that tick is discarded
  always_comb begin
    state_nxt      = state;
    eighth_cnt_nxt = eighth_cnt;
    held_tone_nxt  = held_tone;
    run_len_nxt    = run_len;
    fifo_push      = 1'b0;
    push_ev        = '0;
    ovf_clr        = 1'b0;
    case (state)
      IDLE: begin
        if (start_in && !stop_in) begin
          state_nxt      = COUNT_IN;
          eighth_cnt_nxt = '0;
          ovf_clr        = 1'b1;
        end
      end
      COUNT_IN: begin
        if (stop_in) begin
          state_nxt = IDLE;
        end else if (tick) begin
          eighth_cnt_nxt = eighth_cnt + 3'd1;
          if (eighth_cnt == 3'd7) begin
            state_nxt     = TRACK;
            held_tone_nxt = sample;
            run_len_nxt   = '0;
          end
        end
      end
      TRACK: begin
        if (stop_in) begin
          state_nxt = FLUSH;
        end else if (tick) begin
          if (sample == held_tone) begin
            if (run_len == 4'd7) begin
              fifo_push   = 1'b1;
              push_ev     = make_event(held_tone, WHOLE);
              run_len_nxt = '0;
            end else begin
              run_len_nxt = run_len + 4'd1;
            end
          end else begin
            if (run_len != '0) begin
              fifo_push = 1'b1;
              push_ev   = make_event(held_tone, quantize_len(run_len));
            end
            held_tone_nxt = sample;
            run_len_nxt   = 4'd1;
          end
        end
      end
      FLUSH: begin
        state_nxt = IDLE;
        if (run_len != '0) begin
          fifo_push = 1'b1;
          push_ev   = make_event(held_tone, quantize_len(run_len));
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_pop = event_valid && event_ready;

  event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .push      (fifo_push),
    .push_data (push_ev),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_ev)
  );

  assign event_valid = !fifo_empty;
  assign event_tone  = head_ev.tone;
  assign event_rest  = head_ev.rest;
  assign event_len   = head_ev.len;

endmodule
